// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master clocking blocks.
//   - FSM state encoding for the SCLK generator (idle / run / gap / done).
//   - Fixed-point helper: ONE for the default 7-bit fraction, plus fp_one() for other widths.
//   - CPHA strobe-selection encoding and the helper that classifies an edge as sampling.
package spi_pkg;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StGap  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam int unsigned SpiFracW = 7;

  function automatic int unsigned fp_one(input int unsigned frac_w);
    return 32'd1 << frac_w;
  endfunction

  localparam int unsigned ONE = 32'd1 << SpiFracW;

  // CPHA value meaning: which half of each SCLK cycle carries the sampling edge.
  localparam logic CphaSampleLead  = 1'b0;
  localparam logic CphaSampleTrail = 1'b1;

  // Edge index parity: even = leading, odd = trailing. Every edge that is not a sampling
  // edge is a shifting edge.
  function automatic logic is_sample_edge(input logic cpha, input logic trailing);
    return (cpha == CphaSampleTrail) ? trailing : ~trailing;
  endfunction

endpackage

// File: rtl/spi_frac_accum.sv
// Fixed-point half-period accumulator with edge-fire compare.
// Holds the half-period (integer.fraction) and counts down by ONE per advance; an edge fires
// when less than two whole cycles remain, and the half-period is added back. Fractional
// half-periods therefore produce dithered spacing (2.5 -> 2,3,2,3...).
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   load         : capture div_eff and preload the accumulator with it
//   advance      : step the accumulator by one cycle (caller applies clock enable)
//   div_eff      : half-period, already clamped to >= ONE by the caller
//   fire         : high during an advance cycle in which an edge fires
module spi_frac_accum
  import spi_pkg::*;
#(
  parameter int unsigned DIV_W  = 32,
  parameter int unsigned FRAC_W = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             advance,
  input  logic [DIV_W-1:0] div_eff,
  output logic             fire
);

  localparam logic [DIV_W:0] One    = (DIV_W+1)'(fp_one(FRAC_W));
  localparam logic [DIV_W:0] TwoOne = One << 1;

  // One extra bit so acc - ONE + div cannot overflow (acc < 2*ONE whenever div is added).
  logic [DIV_W:0]   acc_q, acc_d;
  logic [DIV_W-1:0] div_q, div_d;

  assign fire = advance && (acc_q < TwoOne);

  always_comb begin
    acc_d = acc_q;
    div_d = div_q;
    if (load) begin
      acc_d = {1'b0, div_eff};
      div_d = div_eff;
    end else if (advance) begin
      acc_d = fire ? (acc_q - One + {1'b0, div_q}) : (acc_q - One);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q <= '0;
      div_q <= '0;
    end else begin
      acc_q <= acc_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/spi_sclk_generator.sv
// Fractional SCLK generator for the SPI master.
// On an accepted start it runs num_bits SCLK cycles with a fixed-point half-period, applies
// CPOL/CPHA and emits one-cycle sample/shift strobes, then pulses done.
// Optional feature macro: SPI_SCLK_INTERBYTE_GAP_EN adds gap_cycles, an idle gap (SCLK at
// CPOL) between the last edge and done.
// Ports:
//   clock, reset     : system clock, synchronous active-high reset (wins over enable)
//   enable           : clock enable; low freezes all state and masks all strobes
//   div_n            : SCLK half-period in cycles, FRAC_W fraction bits; < 1.0 acts as 1.0
//   cpol, cpha       : SPI mode; latched at accept
//   num_bits         : SCLK cycles per burst; 0 means start is ignored
//   start            : request; accepted only when idle, not busy and enabled
//   gap_cycles       : (macro only) enabled cycles of gap after the last edge
//   sclk             : SPI clock
//   sample_pulse     : strobe on each sampling edge
//   shift_pulse      : strobe on each shifting edge
//   busy             : high from the cycle after accept through the done cycle
//   done             : one-cycle strobe at burst end
module spi_sclk_generator
  import spi_pkg::*;
#(
  parameter int unsigned DIV_W  = 32,
  parameter int unsigned FRAC_W = 7,
  parameter int unsigned CNT_W  = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [DIV_W-1:0] div_n,
  input  logic             cpol,
  input  logic             cpha,
  input  logic [CNT_W-1:0] num_bits,
  input  logic             start,
`ifdef SPI_SCLK_INTERBYTE_GAP_EN
  input  logic [7:0]       gap_cycles,
`endif
  output logic             sclk,
  output logic             sample_pulse,
  output logic             shift_pulse,
  output logic             busy,
  output logic             done
);

  localparam logic [DIV_W-1:0] OneFp = DIV_W'(fp_one(FRAC_W));

  logic [1:0]       state_q, state_d;
  logic             cpol_q, cpol_d;
  logic             cpha_q, cpha_d;
  logic [CNT_W-1:0] nbits_q, nbits_d;
  logic [CNT_W:0]   cnt_q, cnt_d;
  logic             sclk_q, sclk_d;
  logic             sample_q, sample_d;
  logic             shift_q, shift_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
`ifdef SPI_SCLK_INTERBYTE_GAP_EN
  logic [7:0]       gap_q, gap_d;
  logic [7:0]       gap_cnt_q, gap_cnt_d;
`endif

  logic             accept;
  logic             advance;
  logic             fire;
  logic             last_edge;
  logic [DIV_W-1:0] div_eff;

  assign div_eff   = (div_n < OneFp) ? OneFp : div_n;
  // busy_q is still high in the cycle after DONE, so a start there is ignored as well.
  assign accept    = enable && (state_q == StIdle) && !busy_q && start && (num_bits != '0);
  assign advance   = enable && (state_q == StRun);
  assign last_edge = (cnt_q == ({nbits_q, 1'b0} - (CNT_W+1)'(1)));

  spi_frac_accum #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_accum (
    .clock   (clock),
    .reset   (reset),
    .load    (accept),
    .advance (advance),
    .div_eff (div_eff),
    .fire    (fire)
  );

  always_comb begin
    state_d  = state_q;
    cpol_d   = cpol_q;
    cpha_d   = cpha_q;
    nbits_d  = nbits_q;
    cnt_d    = cnt_q;
    sclk_d   = sclk_q;
    sample_d = sample_q;
    shift_d  = shift_q;
    done_d   = done_q;
    busy_d   = busy_q;
`ifdef SPI_SCLK_INTERBYTE_GAP_EN
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
`endif
    if (enable) begin
      // Strobes last exactly one enabled cycle.
      sample_d = 1'b0;
      shift_d  = 1'b0;
      done_d   = 1'b0;
      unique case (state_q)
        StIdle: begin
          sclk_d = cpol;
          busy_d = accept;
          if (accept) begin
            state_d = StRun;
            cpol_d  = cpol;
            cpha_d  = cpha;
            nbits_d = num_bits;
            cnt_d   = '0;
`ifdef SPI_SCLK_INTERBYTE_GAP_EN
            gap_d   = gap_cycles;
`endif
          end
        end
        StRun: begin
          if (fire) begin
            sclk_d = ~sclk_q;
            cnt_d  = cnt_q + (CNT_W+1)'(1);
            if (is_sample_edge(cpha_q, cnt_q[0])) begin
              sample_d = 1'b1;
            end else begin
              shift_d = 1'b1;
            end
            if (last_edge) begin
`ifdef SPI_SCLK_INTERBYTE_GAP_EN
              state_d   = (gap_q == 8'd0) ? StDone : StGap;
              gap_cnt_d = gap_q;
`else
              state_d = StDone;
`endif
            end
          end
        end
        StGap: begin
`ifdef SPI_SCLK_INTERBYTE_GAP_EN
          gap_cnt_d = gap_cnt_q - 8'd1;
          if (gap_cnt_q == 8'd1) begin
            state_d = StDone;
          end
`else
          state_d = StIdle;
`endif
        end
        StDone: begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      nbits_q   <= '0;
      cnt_q     <= '0;
      sclk_q    <= 1'b0;
      sample_q  <= 1'b0;
      shift_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef SPI_SCLK_INTERBYTE_GAP_EN
      gap_q     <= '0;
      gap_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      nbits_q   <= nbits_d;
      cnt_q     <= cnt_d;
      sclk_q    <= sclk_d;
      sample_q  <= sample_d;
      shift_q   <= shift_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
`ifdef SPI_SCLK_INTERBYTE_GAP_EN
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
`endif
    end
  end

  assign sclk         = sclk_q;
  assign busy         = busy_q;
  // A strobe that lands on a disabled cycle is held and shows in the next enabled cycle.
  assign sample_pulse = sample_q & enable;
  assign shift_pulse  = shift_q & enable;
  assign done         = done_q & enable;

endmodule

// File: tb/tb_spi_sclk_generator.sv
// Bench for spi_sclk_generator. The reference model counts enabled cycles since accept and
// places edge j at enabled cycle floor((j+1)*div_eff/ONE); sclk, strobes, done and busy are
// all derived from that schedule.
module tb_spi_sclk_generator;

  localparam int unsigned ONE = 128;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] div_n = '0;
  logic        cpol = 1'b0;
  logic        cpha = 1'b0;
  logic [5:0]  num_bits = '0;
  logic        start = 1'b0;
`ifdef SPI_SCLK_INTERBYTE_GAP_EN
  logic [7:0]  gap_cycles = '0;
`endif
  logic        sclk, sample_pulse, shift_pulse, busy, done;

  int n_vec = 0;
  int n_err = 0;
  int cnt_busy, cnt_samp, cnt_shift, cnt_done;

  // Reference model state.
  bit     m_active;
  bit     m_idle_sclk;
  bit     m_cpol, m_cpha;
  int     m_n, m_gap;
  longint m_k, m_kl, m_d;

  always #5 clock = ~clock;

  spi_sclk_generator #(
    .DIV_W  (32),
    .FRAC_W (7),
    .CNT_W  (6)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .div_n        (div_n),
    .cpol         (cpol),
    .cpha         (cpha),
    .num_bits     (num_bits),
    .start        (start),
`ifdef SPI_SCLK_INTERBYTE_GAP_EN
    .gap_cycles   (gap_cycles),
`endif
    .sclk         (sclk),
    .sample_pulse (sample_pulse),
    .shift_pulse  (shift_pulse),
    .busy         (busy),
    .done         (done)
  );

  function automatic longint edge_k(input int j);
    return ((longint'(j) + 1) * m_d) / ONE;
  endfunction

  task automatic cmp(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cmp_int(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs == exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check();
    bit e_sclk, e_samp, e_shift, e_busy, e_done;
    int fired;
    e_sclk = 1'b0; e_samp = 1'b0; e_shift = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    fired = 0;
    if (m_active) begin
      e_busy = 1'b1;
      for (int j = 0; j < 2 * m_n; j++) begin
        longint kj;
        kj = edge_k(j);
        if (kj <= m_k) fired++;
        if (kj == m_k) begin
          e_samp  = ((j % 2) == int'(m_cpha));
          e_shift = !e_samp;
        end
      end
      e_sclk = m_cpol ^ fired[0];
      e_done = (m_k == m_kl + 1 + m_gap);
    end else begin
      e_sclk = m_idle_sclk;
    end
    e_samp  = e_samp & enable;
    e_shift = e_shift & enable;
    e_done  = e_done & enable;
    cmp("sclk", sclk, e_sclk);
    cmp("sample_pulse", sample_pulse, e_samp);
    cmp("shift_pulse", shift_pulse, e_shift);
    cmp("busy", busy, e_busy);
    cmp("done", done, e_done);
    if (busy === 1'b1) cnt_busy++;
    if (sample_pulse === 1'b1) cnt_samp++;
    if (shift_pulse === 1'b1) cnt_shift++;
    if (done === 1'b1) cnt_done++;
  endtask

  task automatic model_edge();
    if (reset) begin
      m_active    = 1'b0;
      m_idle_sclk = 1'b0;
    end else if (enable) begin
      if (m_active) begin
        m_k++;
        if (m_k == m_kl + 2 + m_gap) begin
          m_active    = 1'b0;
          m_idle_sclk = cpol;
        end
      end else begin
        m_idle_sclk = cpol;
        if (start && num_bits != 0) begin
          m_active = 1'b1;
          m_k      = 0;
          m_d      = (div_n < ONE) ? ONE : longint'(div_n);
          m_n      = int'(num_bits);
          m_cpol   = cpol;
          m_cpha   = cpha;
`ifdef SPI_SCLK_INTERBYTE_GAP_EN
          m_gap    = int'(gap_cycles);
`else
          m_gap    = 0;
`endif
          m_kl     = edge_k(2 * m_n - 1);
        end
      end
    end
  endtask

  task automatic step(input bit en, input bit st);
    enable = en;
    start  = st;
    #1;
    check();
    @(posedge clock);
    model_edge();
    #2;
  endtask

  // mode 0: enable always high; 1: enable 1,0,1,0...; 2: random enable and input churn.
  task automatic run_burst(input int div, input bit pol, input bit pha, input int nb,
                           input int gap, input int mode);
    div_n = div; cpol = pol; cpha = pha; num_bits = nb[5:0];
`ifdef SPI_SCLK_INTERBYTE_GAP_EN
    gap_cycles = gap[7:0];
`endif
    cnt_busy = 0; cnt_samp = 0; cnt_shift = 0; cnt_done = 0;
    step(1'b1, 1'b1);
    for (int i = 0; i < 20000 && m_active; i++) begin
      bit en, st;
      en = 1'b1;
      if (mode == 1) en = (i % 2 == 0);
      if (mode == 2) en = ($urandom_range(3) != 0);
      st = (mode != 0) && ($urandom_range(5) == 0);
      if (mode == 2 && $urandom_range(3) == 0) begin
        div_n = $urandom_range(1024); cpol = 1'($urandom); cpha = 1'($urandom);
        num_bits = 6'($urandom);
      end
      step(en, st);
    end
    if (m_active) begin
      n_err++;
      $display("FAIL burst_bound observed=running expected=finished");
    end
  endtask

  initial begin
    m_active = 1'b0; m_idle_sclk = 1'b0; m_k = 0; m_kl = 0; m_d = ONE; m_n = 0; m_gap = 0;
    m_cpol = 1'b0; m_cpha = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // 4.0 half-period, mode 0, 8 bits.
    run_burst(32'h200, 1'b0, 1'b0, 8, 0, 0);
    cmp_int("busy_cycles", cnt_busy, 66);
    cmp_int("sample_count", cnt_samp, 8);
    cmp_int("shift_count", cnt_shift, 8);
    cmp_int("done_count", cnt_done, 1);
    step(1'b1, 1'b0);

    // 2.5 half-period, cpol=1.
    run_burst(32'h140, 1'b1, 1'b0, 2, 0, 0);
    cmp_int("sample_count_2p5", cnt_samp, 2);
    step(1'b1, 1'b0);

    // cpha=1, single bit, then at the 1.0 floor.
    run_burst(32'h200, 1'b0, 1'b1, 1, 0, 0);
    cmp_int("cpha1_sample", cnt_samp, 1);
    cmp_int("cpha1_shift", cnt_shift, 1);
    run_burst(32'h10, 1'b0, 1'b1, 1, 0, 0);
    cmp_int("fast_busy_cycles", cnt_busy, 4);

    // Alternating enable with starts while busy; then num_bits=0 start is ignored.
    run_burst(32'h180, 1'b0, 1'b0, 4, 0, 1);
    cmp_int("toggle_done_count", cnt_done, 1);
    num_bits = 6'd0;
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);

    // Reset right after edge 5.
    div_n = 32'h200; cpol = 1'b0; cpha = 1'b0; num_bits = 6'd8;
    cnt_done = 0;
    step(1'b1, 1'b1);
    for (int i = 0; i < 200 && !(m_active && m_k >= edge_k(5)); i++) step(1'b1, 1'b0);
    reset = 1'b1;
    step(1'b1, 1'b0);
    reset = 1'b0;
    step(1'b1, 1'b0);
    cmp_int("reset_no_done", cnt_done, 0);
    run_burst(32'h200, 1'b0, 1'b0, 8, 0, 0);
    cmp_int("post_reset_busy", cnt_busy, 66);

`ifdef SPI_SCLK_INTERBYTE_GAP_EN
    run_burst(32'h200, 1'b0, 1'b0, 8, 3, 0);
    cmp_int("gap3_busy", cnt_busy, 69);
    run_burst(32'h200, 1'b0, 1'b0, 8, 0, 0);
    cmp_int("gap0_busy", cnt_busy, 66);
`endif

    // Random bursts.
    for (int b = 0; b < 12; b++) begin
      run_burst(int'($urandom_range(768)), 1'($urandom), 1'($urandom),
                int'($urandom_range(5, 1)), int'($urandom_range(4)), 2);
      step(1'($urandom), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_sclk_generator.md
Name: spi_sclk_generator

Overview:
- Parametrised fractional SCLK generator for the SPI master.
- Fixed-point half-period accumulator (integer.fraction) produces SCLK edges with a configurable half-period.
- Runs a burst of num_bits SCLK cycles, applies CPOL/CPHA, and emits single-cycle sample/shift strobes to the shift register.
- Replaces the free-running divide-by-N clock with a start/busy/done handshake, and with clock-enable qualification instead of a gated clock.

Parameters:
- DIV_W, 32: width of the div_n fixed-point half-period.
- FRAC_W, 7: fractional bits of div_n. ONE = 1<<FRAC_W.
- CNT_W, 6: width of num_bits and the internal edge counter. Edge counter is CNT_W+1 bits.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  clock-enable qualifier. Low freezes all state. All strobes are 0 while low.
- div_n  in  DIV_W  SCLK half-period in clock cycles, unsigned fixed point with FRAC_W fraction bits.
- cpol  in  1  idle SCLK level.
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge.
- num_bits  in  CNT_W  SCLK cycles per burst. 0 is illegal; start is ignored.
- start  in  1  single-cycle request. Accepted only in IDLE with enable=1.
- sclk  out  1  SPI clock.
- sample_pulse  out  1  one-cycle strobe at each sampling edge.
- shift_pulse  out  1  one-cycle strobe at each shifting edge.
- busy  out  1  high from the cycle after accept until return to IDLE.
- done  out  1  one-cycle strobe at burst end.

Behaviour:
- Reset values: sclk=0, all strobes=0, busy=0, done=0. State=IDLE, acc=0, edge counter=0, latched config=0.
- reset has priority over enable. Reset mid-burst aborts the burst immediately; done is not pulsed.
- Only the enable=1 cycles advance state, accumulator or counters.
- IDLE:
  - sclk <= cpol each enabled cycle.
  - On accept, latch div_eff=max(div_n,ONE), cpol, cpha and num_bits. Set acc <= div_eff and edge counter <= 0. Go to RUN.
  - Input changes while busy have no effect.
- RUN, per enabled cycle:
  - If acc < 2*ONE: edge fires. acc <= acc - ONE + div_eff; sclk toggles; edge counter increments.
  - Otherwise: acc <= acc - ONE.
- Edge spacing: div_n=4.0 gives an edge every 4 cycles. div_n=2.5 alternates 2,3,2,3. div_n<1.0 behaves as 1.0, i.e. an edge every enabled cycle.
- Edge classification: even edge index = leading, odd = trailing.
  - cpha=0: sample_pulse on leading edges, shift_pulse on trailing edges.
  - cpha=1: shift_pulse on leading edges, sample_pulse on trailing edges.
- Strobes are registered and asserted in the same cycle sclk changes.
- Burst end: after edge index 2*num_bits-1 (the last trailing edge), go to DONE. sclk now equals the latched cpol.
- DONE: done=1 for one enabled cycle, then IDLE. busy falls with the IDLE transition. A start in the DONE cycle is ignored.
- Arithmetic: acc is DIV_W+1 bits, so acc - ONE + div_eff cannot overflow. Edge counter is CNT_W+1 bits, which covers 2*(2^CNT_W - 1) edges.

Optional Feature:
- Macro SPI_SCLK_INTERBYTE_GAP_EN.
- Defined:
  - Adds input gap_cycles [7:0], latched at accept.
  - After the last edge, enter GAP. sclk is held at cpol for gap_cycles enabled cycles, then DONE.
  - gap_cycles=0 goes straight to DONE.
- Undefined: no port, no GAP state; RUN goes directly to DONE.

Decomposition:
- Shared package spi_pkg:
  - state encoding IDLE/RUN/GAP/DONE;
  - localparam ONE;
  - the CPHA strobe-selection encoding.
- One natural sub-module, spi_frac_accum: accumulator plus edge-fire compare, taking div_eff/load/advance and returning edge. Reusable for the CS-to-SCLK delay timer.

Test Plan:
- div_n=4.0 (0x200), cpol=0, cpha=0, num_bits=8, enable=1, start pulse:
  - 16 edges spaced 4 cycles apart, the first edge 4 cycles after accept;
  - sclk rises on edge 0;
  - 8 sample and 8 shift pulses;
  - done 1 cycle after the last edge; busy high for exactly 66 cycles.
- div_n=2.5 (0x140), num_bits=2: edge spacing 2,3,2,3. cpol=1: sclk idles high and ends high.
- cpha=1, num_bits=1: shift_pulse on edge 0, sample_pulse on edge 1. Repeat with div_n=0x10: edges every cycle.
- enable toggled 1,0,1,0 mid-burst: edge timing stretches by the disabled cycles; no strobes while enable=0. start while busy or num_bits=0 is ignored.
- Assert reset at edge 5: next cycle sclk=0, busy=0, no done. A new start then runs normally.
- With SPI_SCLK_INTERBYTE_GAP_EN, gap_cycles=3: done is delayed exactly 3 enabled cycles after the last edge. gap_cycles=0 matches the no-macro timing.
